retire_ctrl: RTL and testbench

In-order retirement sequencer for the order queue (32-entry Rd-tag FIFO) in the Tomasulo datapath.
- Tracks completion of each Rd tag from CDB broadcasts.
- Pops the queue head once that tag has completed, and reports each retired or flushed tag so the free-tag pool can reclaim it.
- On a flush request, drains the whole queue one entry per cycle.

---
 rtl/retire_ctrl.sv | 95 +++++++++
 tb/tb_retire_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/retire_ctrl.sv
// In-order retirement sequencer for the Tomasulo order queue: retires completed
// head tags, drains the queue on a flush, and hands every released tag back to the free pool.
module retire_ctrl #(
    parameter int TAG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [TAG_W-1:0] oq_head_tag,
    input  logic             oq_empty,
    output logic             oq_pop,
    input  logic             dispatch_valid,
    input  logic [TAG_W-1:0] dispatch_tag,
    input  logic             cdb_valid,
    input  logic [TAG_W-1:0] cdb_tag,
    input  logic             retire_en,
    input  logic             flush,
    output logic             free_valid,
    output logic [TAG_W-1:0] free_tag,
    output logic             free_is_flush,
    output logic             flushing,
    output logic [CNT_W-1:0] retired_count
);

    localparam int NTAGS = 2**TAG_W;

    typedef enum logic {RUN, FLUSH} state_t;

    state_t           state;
    logic [NTAGS-1:0] complete;
    logic [NTAGS-1:0] complete_next;
    logic             in_flush;

    assign in_flush = (state == FLUSH);
    assign flushing = in_flush;

    // The completion bit is read from the registered vector only, so a CDB
    // broadcast can release the head no earlier than the following cycle.
    always_comb begin
        oq_pop = 1'b0;
        if (in_flush)
            oq_pop = !oq_empty;
        else
            oq_pop = !oq_empty && complete[oq_head_tag] && retire_en;
    end

    // Clears are applied after the set so a dispatch of the same tag wins.
    always_comb begin
        complete_next = complete;
        if (cdb_valid && !in_flush)
            complete_next[cdb_tag] = 1'b1;
        if (oq_pop)
            complete_next[oq_head_tag] = 1'b0;
        if (dispatch_valid)
            complete_next[dispatch_tag] = 1'b0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= RUN;
            complete      <= '0;
            free_valid    <= 1'b0;
            free_tag      <= '0;
            free_is_flush <= 1'b0;
            retired_count <= '0;
        end else begin
            free_valid <= oq_pop;
            if (oq_pop) begin
                free_tag      <= oq_head_tag;
                free_is_flush <= in_flush;
            end
            if (oq_pop && !in_flush)
                retired_count <= retired_count + CNT_W'(1);

            case (state)
                RUN: begin
                    complete <= complete_next;
                    if (flush)
                        state <= FLUSH;
                end
                FLUSH: begin
                    // Leaving FLUSH wipes every stale completion in one go.
                    if (oq_empty) begin
                        complete <= '0;
                        state    <= RUN;
                    end else begin
                        complete <= complete_next;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_retire_ctrl.sv
// Bench for retire_ctrl: plays the order queue, predicts every output from a
// tag-queue model, and adds directed scenarios with hand-computed expectations.
module tb_retire_ctrl;

    localparam int TAG_W = 5;
    localparam int CNT_W = 16;
    localparam int NTAGS = 2**TAG_W;

    logic             clock;
    logic             reset;
    logic [TAG_W-1:0] oq_head_tag;
    logic             oq_empty;
    logic             oq_pop;
    logic             dispatch_valid;
    logic [TAG_W-1:0] dispatch_tag;
    logic             cdb_valid;
    logic [TAG_W-1:0] cdb_tag;
    logic             retire_en;
    logic             flush;
    logic             free_valid;
    logic [TAG_W-1:0] free_tag;
    logic             free_is_flush;
    logic             flushing;
    logic [CNT_W-1:0] retired_count;

    int n_vec = 0;
    int n_err = 0;

    // Model: the order queue contents, which tags have completed, and the expected registered outputs.
    int m_q[$];
    bit m_done[NTAGS];
    bit m_flush;
    bit m_fv;
    int m_ftag;
    bit m_fisf;
    int m_count;

    retire_ctrl #(.TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
        .clock(clock),
        .reset(reset),
        .oq_head_tag(oq_head_tag),
        .oq_empty(oq_empty),
        .oq_pop(oq_pop),
        .dispatch_valid(dispatch_valid),
        .dispatch_tag(dispatch_tag),
        .cdb_valid(cdb_valid),
        .cdb_tag(cdb_tag),
        .retire_en(retire_en),
        .flush(flush),
        .free_valid(free_valid),
        .free_tag(free_tag),
        .free_is_flush(free_is_flush),
        .flushing(flushing),
        .retired_count(retired_count)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_vec++;
        if (actual != expected) begin
            n_err++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic modelReset();
        m_q.delete();
        foreach (m_done[i]) m_done[i] = 1'b0;
        m_flush     = 1'b0;
        m_fv        = 1'b0;
        m_ftag      = 0;
        m_fisf      = 1'b0;
        m_count     = 0;
        oq_empty    = 1'b1;
        oq_head_tag = '0;
    endtask

    task automatic applyStimulus(input int dv, input int dtag, input int cv, input int ctag,
                                 input int ren, input int fl);
        dispatch_valid = (dv != 0);
        dispatch_tag   = TAG_W'(dtag);
        cdb_valid      = (cv != 0);
        cdb_tag        = TAG_W'(ctag);
        retire_en      = (ren != 0);
        flush          = (fl != 0);
        #1;
    endtask

    task automatic idle();
        applyStimulus(0, 0, 0, 0, 1, 0);
    endtask

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    // Compare every cycle at the falling edge, then advance the model and the
    // order-queue image just after the rising edge.
    initial begin : model
        bit e_pop;
        bit nonempty;
        bit valid;
        int head;
        bit c_dv, c_cv, c_fl;
        int c_dtag, c_ctag;
        modelReset();
        forever begin
            @(negedge clock);
            valid = 1'b0;
            if (reset) begin
                modelReset();
            end else begin
                nonempty = (m_q.size() > 0);
                head     = nonempty ? m_q[0] : 0;
                e_pop    = m_flush ? nonempty : (nonempty && m_done[head] && retire_en);
                checkOutput("oq_pop", int'(oq_pop), int'(e_pop));
                checkOutput("flushing", int'(flushing), int'(m_flush));
                checkOutput("free_valid", int'(free_valid), int'(m_fv));
                checkOutput("retired_count", int'(retired_count), m_count);
                if (m_fv) begin
                    checkOutput("free_tag", int'(free_tag), m_ftag);
                    checkOutput("free_is_flush", int'(free_is_flush), int'(m_fisf));
                end
                c_dv   = dispatch_valid;
                c_dtag = int'(dispatch_tag);
                c_cv   = cdb_valid;
                c_ctag = int'(cdb_tag);
                c_fl   = flush;
                valid  = 1'b1;
            end
            @(posedge clock);
            #1;
            if (reset) begin
                modelReset();
            end else if (valid) begin
                m_fv = e_pop;
                if (e_pop) begin
                    m_ftag = head;
                    m_fisf = m_flush;
                    if (!m_flush) m_count = (m_count + 1) % (1 << CNT_W);
                end
                if (!m_flush && c_cv) m_done[c_ctag] = 1'b1;
                if (e_pop) m_done[head] = 1'b0;
                if (c_dv) m_done[c_dtag] = 1'b0;
                if (m_flush && !nonempty) begin
                    foreach (m_done[i]) m_done[i] = 1'b0;
                    m_flush = 1'b0;
                end else if (!m_flush && c_fl) begin
                    m_flush = 1'b1;
                end
                if (e_pop) void'(m_q.pop_front());
                if (c_dv) m_q.push_back(c_dtag);
                oq_empty    = (m_q.size() == 0);
                oq_head_tag = (m_q.size() > 0) ? TAG_W'(m_q[0]) : '0;
            end
        end
    end

    initial begin : stimulus
        int n;
        reset = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0);
        tick();
        tick();
        checkOutput("reset_oq_pop", int'(oq_pop), 0);
        checkOutput("reset_free_valid", int'(free_valid), 0);
        checkOutput("reset_free_tag", int'(free_tag), 0);
        checkOutput("reset_free_is_flush", int'(free_is_flush), 0);
        checkOutput("reset_flushing", int'(flushing), 0);
        checkOutput("reset_count", int'(retired_count), 0);
        reset = 1'b0;

        // Basic retire of 3 then 7
        applyStimulus(1, 3, 0, 0, 1, 0); tick();
        applyStimulus(1, 7, 0, 0, 1, 0); tick();
        applyStimulus(0, 0, 1, 3, 1, 0);
        checkOutput("s1_no_bypass", int'(oq_pop), 0); tick();
        idle();
        checkOutput("s1_pop3", int'(oq_pop), 1); tick();
        applyStimulus(0, 0, 1, 7, 1, 0);
        checkOutput("s1_free_valid", int'(free_valid), 1);
        checkOutput("s1_free_tag3", int'(free_tag), 3);
        checkOutput("s1_free_commit", int'(free_is_flush), 0);
        checkOutput("s1_count1", int'(retired_count), 1); tick();
        idle();
        checkOutput("s1_pop7", int'(oq_pop), 1); tick();
        idle();
        checkOutput("s1_free_tag7", int'(free_tag), 7);
        checkOutput("s1_count2", int'(retired_count), 2); tick();

        // Out-of-order completion: head 7 completes after 3
        applyStimulus(1, 7, 0, 0, 1, 0); tick();
        applyStimulus(1, 3, 0, 0, 1, 0); tick();
        applyStimulus(0, 0, 1, 3, 1, 0);
        checkOutput("s2_wait_cdb3", int'(oq_pop), 0); tick();
        applyStimulus(0, 0, 1, 7, 1, 0);
        checkOutput("s2_wait_cdb7", int'(oq_pop), 0); tick();
        idle();
        checkOutput("s2_pop7", int'(oq_pop), 1); tick();
        idle();
        checkOutput("s2_pop3", int'(oq_pop), 1);
        checkOutput("s2_free_tag7", int'(free_tag), 7); tick();
        idle();
        checkOutput("s2_empty", int'(oq_pop), 0);
        checkOutput("s2_free_tag3", int'(free_tag), 3);
        checkOutput("s2_count4", int'(retired_count), 4); tick();

        // Backpressure on a completed head
        applyStimulus(1, 5, 0, 0, 0, 0); tick();
        applyStimulus(0, 0, 1, 5, 0, 0);
        checkOutput("s3_cdb_cycle", int'(oq_pop), 0); tick();
        for (int k = 0; k < 4; k++) begin
            applyStimulus(0, 0, 0, 0, 0, 0);
            checkOutput("s3_stalled", int'(oq_pop), 0); tick();
        end
        idle();
        checkOutput("s3_release", int'(oq_pop), 1); tick();
        idle();
        checkOutput("s3_free_tag5", int'(free_tag), 5);
        checkOutput("s3_count5", int'(retired_count), 5); tick();

        // Flush drains 1,2,3,4 without counting
        for (int t = 1; t <= 4; t++) begin
            applyStimulus(1, t, 0, 0, 0, 0); tick();
        end
        applyStimulus(0, 0, 1, 1, 0, 0);
        checkOutput("s4_no_pop", int'(oq_pop), 0); tick();
        applyStimulus(0, 0, 0, 0, 0, 1);
        checkOutput("s4_flush_cycle_pop", int'(oq_pop), 0);
        checkOutput("s4_flush_cycle_run", int'(flushing), 0); tick();
        for (int k = 0; k < 4; k++) begin
            idle();
            checkOutput("s4_flushing", int'(flushing), 1);
            checkOutput("s4_drain_pop", int'(oq_pop), 1);
            if (k > 0) begin
                checkOutput("s4_free_valid", int'(free_valid), 1);
                checkOutput("s4_free_tag", int'(free_tag), k);
                checkOutput("s4_free_is_flush", int'(free_is_flush), 1);
            end
            tick();
        end
        idle();
        checkOutput("s4_last_flushing", int'(flushing), 1);
        checkOutput("s4_last_pop", int'(oq_pop), 0);
        checkOutput("s4_free_tag4", int'(free_tag), 4);
        checkOutput("s4_free4_flush", int'(free_is_flush), 1); tick();
        idle();
        checkOutput("s4_back_to_run", int'(flushing), 0);
        checkOutput("s4_no_free", int'(free_valid), 0);
        checkOutput("s4_count_kept", int'(retired_count), 5); tick();

        // Dispatch clear beats a same-cycle CDB set
        applyStimulus(1, 9, 1, 9, 1, 0); tick();
        for (int k = 0; k < 3; k++) begin
            idle();
            checkOutput("s5_not_complete", int'(oq_pop), 0); tick();
        end
        applyStimulus(0, 0, 1, 9, 1, 0);
        checkOutput("s5_cdb_cycle", int'(oq_pop), 0); tick();
        idle();
        checkOutput("s5_pop9", int'(oq_pop), 1); tick();
        idle();
        checkOutput("s5_free_tag9", int'(free_tag), 9);
        checkOutput("s5_count6", int'(retired_count), 6); tick();

        // Flush with an empty queue lasts one cycle
        applyStimulus(0, 0, 0, 0, 1, 1);
        checkOutput("s6_still_run", int'(flushing), 0); tick();
        idle();
        checkOutput("s6_flush_one", int'(flushing), 1);
        checkOutput("s6_no_pop", int'(oq_pop), 0); tick();
        idle();
        checkOutput("s6_run_again", int'(flushing), 0); tick();

        // Back-to-back retirements until the counter wraps
        n = (1 << CNT_W) - m_count;
        for (int i = 0; i < n; i++) begin
            applyStimulus(1, i % NTAGS, (i > 0) ? 1 : 0, (i + NTAGS - 1) % NTAGS, 1, 0);
            tick();
        end
        applyStimulus(0, 0, 1, (n - 1) % NTAGS, 1, 0); tick();
        idle(); tick();
        idle(); tick();
        checkOutput("s7_count_wrap", int'(retired_count), 0);

        // Asynchronous reset in the middle of a flush
        for (int t = 1; t <= 3; t++) begin
            applyStimulus(1, t + 10, 0, 0, 0, 0); tick();
        end
        applyStimulus(0, 0, 0, 0, 0, 1); tick();
        idle();
        checkOutput("s8_in_flush", int'(flushing), 1); tick();
        idle();
        checkOutput("s8_free_pending", int'(free_valid), 1);
        checkOutput("s8_free_tag11", int'(free_tag), 11);
        reset = 1'b1;
        #1;
        checkOutput("s8_async_flushing", int'(flushing), 0);
        checkOutput("s8_async_free_valid", int'(free_valid), 0);
        checkOutput("s8_async_pop", int'(oq_pop), 0);
        tick();
        tick();
        reset = 1'b0;
        idle(); tick();
        checkOutput("s8_run_after_reset", int'(flushing), 0);
        checkOutput("s8_count_cleared", int'(retired_count), 0);
        idle(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
